fruit_launch_scheduler: RTL and testbench

//  Game-level sequencer for NUM_SLOTS coord_generator fruit slots. Staggers slot start-up,

---
 rtl/fruit_launch_scheduler_pkg.sv | 25 ++
 rtl/fruit_launch_scheduler_lfsr16.sv | 16 +
 rtl/fruit_launch_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_fruit_launch_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fruit_launch_scheduler_pkg.sv
// Shared definitions for the fruit launch scheduler: game states, field widths
// and the 16-bit Galois LFSR step used for launch parameter draws.
package fruit_launch_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_PLAY    = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  localparam int X_W         = 10;
  localparam int YV_W        = 5;
  localparam int FELL_W      = 3;
  localparam int SCORE_W     = 8;
  localparam int TOT_SCORE_W = 10;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/fruit_launch_scheduler_lfsr16.sv
// Free-running 16-bit Galois LFSR; loads the seed on reset and steps every frame.
module lfsr16
  import fruit_launch_scheduler_pkg::*;
(
  input  logic        vsync,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  always_ff @(posedge vsync) begin
    if (reset) out <= seed;
    else       out <= lfsr_step(out);
  end

endmodule

// File: rtl/fruit_launch_scheduler.sv
// Round sequencer for the coord_generator slots: staggered enables, random
// launch parameters per relaunch, summed miss/score totals and round end.
module fruit_launch_scheduler
  import fruit_launch_scheduler_pkg::*;
#(
  parameter int          NUM_SLOTS  = 4,
  parameter int          LAUNCH_GAP = 30,
  parameter int          MAX_FELL   = 3,
  parameter int          YVEL_MIN   = 18,
  parameter int          X_MIN      = 200,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                            vsync,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_SLOTS-1:0]            slot_new,
  input  logic [FELL_W*NUM_SLOTS-1:0]     slot_fell,
  input  logic [SCORE_W*NUM_SLOTS-1:0]    slot_score,
  output logic [NUM_SLOTS-1:0]            slot_rdy,
  output logic [NUM_SLOTS-1:0]            slot_active,
  output logic [NUM_SLOTS-1:0]            slot_back,
  output logic [YV_W*NUM_SLOTS-1:0]       slot_yvel,
  output logic [X_W*NUM_SLOTS-1:0]        slot_xstart,
  output logic [FELL_W-1:0]               total_fell,
  output logic [TOT_SCORE_W-1:0]          total_score,
  output logic                            game_over
);

  localparam int CNT_W  = $clog2((NUM_SLOTS - 1) * LAUNCH_GAP + 2);
  localparam int IDX_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int FSUM_W = FELL_W + $clog2(NUM_SLOTS + 1);

  state_t                   state, state_nxt;
  logic                     start_q, rise;
  logic [CNT_W-1:0]         cnt;
  logic [NUM_SLOTS-1:0]     pending, rdy_stag, draw_clr;
  logic                     init_busy;
  logic [IDX_W-1:0]         init_idx, draw_idx;
  logic                     draw_en;
  logic [FSUM_W-1:0]        fell_raw;
  logic [FELL_W-1:0]        fell_sat;
  logic [TOT_SCORE_W-1:0]   score_sum;
  logic                     over_hit;
  logic [X_W-1:0]           x_draw;
  logic                     back_draw;
  logic [YV_W-1:0]          yv_draw;
  logic                     active_draw;
  logic [15:0]              lfsr;
  logic                     unused_lfsr_msb;

  lfsr16 u_lfsr (
    .vsync (vsync),
    .reset (reset),
    .seed  (LFSR_SEED),
    .out   (lfsr)
  );

  assign unused_lfsr_msb = lfsr[15];
  assign rise            = start & ~start_q;
  assign game_over       = (state == ST_OVER);

  always_comb begin
    fell_raw  = '0;
    score_sum = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      fell_raw  = fell_raw + FSUM_W'(slot_fell[FELL_W*i +: FELL_W]);
      score_sum = score_sum + TOT_SCORE_W'(slot_score[SCORE_W*i +: SCORE_W]);
    end
    fell_sat = (fell_raw > FSUM_W'((1 << FELL_W) - 1)) ? '1 : fell_raw[FELL_W-1:0];
    over_hit = (fell_raw >= FSUM_W'(MAX_FELL));
  end

  // Initial draws (slot 0 upward) take priority; afterwards the lowest pending slot.
  always_comb begin
    draw_en  = 1'b0;
    draw_idx = '0;
    draw_clr = '0;
    if (state == ST_STAGGER || state == ST_PLAY) begin
      if (init_busy) begin
        draw_en  = 1'b1;
        draw_idx = init_idx;
      end else begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
          if (pending[i] && !draw_en) begin
            draw_en     = 1'b1;
            draw_idx    = IDX_W'(i);
            draw_clr[i] = 1'b1;
          end
        end
      end
    end
    rdy_stag = slot_rdy;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (cnt == CNT_W'(i * LAUNCH_GAP)) rdy_stag[i] = 1'b1;
    end
    x_draw      = X_W'(X_MIN) + {1'b0, lfsr[8:0]};
    back_draw   = (x_draw > X_W'(512));
    yv_draw     = YV_W'(YVEL_MIN) + {2'b00, lfsr[11:9]};
    active_draw = |lfsr[14:12];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_OVER: if (rise) state_nxt = ST_STAGGER;
      ST_STAGGER: begin
        if (over_hit)        state_nxt = ST_OVER;
        else if (&rdy_stag)  state_nxt = ST_PLAY;
      end
      ST_PLAY:    if (over_hit) state_nxt = ST_OVER;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge vsync) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge vsync) begin
    if (reset) begin
      start_q     <= 1'b0;
      cnt         <= '0;
      pending     <= '0;
      init_busy   <= 1'b0;
      init_idx    <= '0;
      slot_rdy    <= '0;
      slot_active <= '1;
      slot_back   <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slot_yvel[YV_W*i +: YV_W]  <= YV_W'(YVEL_MIN);
        slot_xstart[X_W*i +: X_W]  <= X_W'(X_MIN);
      end
      total_fell  <= '0;
      total_score <= '0;
    end else begin
      start_q <= start;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (rise) begin
            total_fell  <= '0;
            total_score <= '0;
            cnt         <= '0;
            init_busy   <= 1'b1;
            init_idx    <= '0;
            pending     <= '0;
          end
        end
        ST_STAGGER, ST_PLAY: begin
          total_fell  <= fell_sat;
          total_score <= score_sum;
          if (over_hit) begin
            slot_rdy  <= '0;
            init_busy <= 1'b0;
            pending   <= '0;
          end else begin
            if (state == ST_STAGGER) begin
              cnt      <= cnt + 1'b1;
              slot_rdy <= rdy_stag;
            end
            // Relaunches are collected during the stagger too, so an early slot is not lost.
            pending <= (pending & ~draw_clr) | slot_new;
            if (init_busy) begin
              init_idx <= init_idx + 1'b1;
              if (init_idx == IDX_W'(NUM_SLOTS - 1)) init_busy <= 1'b0;
            end
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
              if (draw_en && draw_idx == IDX_W'(i)) begin
                slot_xstart[X_W*i +: X_W]  <= x_draw;
                slot_yvel[YV_W*i +: YV_W]  <= yv_draw;
                slot_back[i]               <= back_draw;
                slot_active[i]             <= active_draw;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fruit_launch_scheduler.sv
// Bench for fruit_launch_scheduler: frame-level reference model compared every
// frame, plus a total-sum vector table and directed round/reset sequences.
module tb_fruit_launch_scheduler;

  localparam int N    = 4;
  localparam int GAP  = 30;
  localparam int MAXF = 3;
  localparam int YMIN = 18;
  localparam int XMIN = 200;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        vsync = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  slot_new = '0;
  logic [11:0] slot_fell = '0;
  logic [31:0] slot_score = '0;
  logic [3:0]  slot_rdy, slot_active, slot_back;
  logic [19:0] slot_yvel;
  logic [39:0] slot_xstart;
  logic [2:0]  total_fell;
  logic [9:0]  total_score;
  logic        game_over;

  int tests = 0;
  int fails = 0;
  int model_fail_prints = 0;

  fruit_launch_scheduler #(
    .NUM_SLOTS (N),
    .LAUNCH_GAP(GAP),
    .MAX_FELL  (MAXF),
    .YVEL_MIN  (YMIN),
    .X_MIN     (XMIN),
    .LFSR_SEED (SEED)
  ) dut (
    .vsync      (vsync),
    .reset      (reset),
    .start      (start),
    .slot_new   (slot_new),
    .slot_fell  (slot_fell),
    .slot_score (slot_score),
    .slot_rdy   (slot_rdy),
    .slot_active(slot_active),
    .slot_back  (slot_back),
    .slot_yvel  (slot_yvel),
    .slot_xstart(slot_xstart),
    .total_fell (total_fell),
    .total_score(total_score),
    .game_over  (game_over)
  );

  always #5 vsync = ~vsync;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge vsync);
    #1;
  endtask

  // ---------------- reference model (frame-level game rules) ----------------
  int          m_state = 0;   // 0 idle, 1 stagger, 2 play, 3 over
  int          m_frames = 0;
  int          m_init = N;
  bit          m_prev_start = 1'b0;
  bit   [3:0]  m_pend = '0;
  logic [15:0] m_lfsr = SEED;
  logic [3:0]  e_rdy = '0, e_active = '1, e_back = '0;
  logic [19:0] e_yvel = {4{5'd18}};
  logic [39:0] e_x = {4{10'd200}};
  logic [2:0]  e_fell = '0;
  logic [9:0]  e_score = '0;

  task automatic model_draw(input int d);
    int x;
    x = XMIN + int'(m_lfsr[8:0]);
    e_x[10*d +: 10]   = 10'(x);
    e_back[d]         = (x > 512);
    e_yvel[5*d +: 5]  = 5'(YMIN + int'(m_lfsr[11:9]));
    e_active[d]       = (m_lfsr[14:12] != 3'd0);
  endtask

  task automatic model_step;
    int fs, ss, d;
    bit rise;
    if (reset) begin
      m_state = 0; m_frames = 0; m_init = N; m_pend = '0; m_prev_start = 1'b0;
      m_lfsr = SEED;
      e_rdy = '0; e_active = '1; e_back = '0;
      e_yvel = {4{5'd18}}; e_x = {4{10'd200}};
      e_fell = '0; e_score = '0;
    end else begin
      rise = start && !m_prev_start;
      fs = 0; ss = 0;
      for (int i = 0; i < N; i++) begin
        fs += int'(slot_fell[3*i +: 3]);
        ss += int'(slot_score[8*i +: 8]);
      end
      if (m_state == 0 || m_state == 3) begin
        if (rise) begin
          m_state = 1; m_frames = 0; m_init = 0; m_pend = '0;
          e_fell = '0; e_score = '0;
        end
      end else begin
        e_fell  = 3'((fs > 7) ? 7 : fs);
        e_score = 10'(ss);
        if (fs >= MAXF) begin
          m_state = 3; e_rdy = '0; m_pend = '0; m_init = N;
        end else begin
          d = -1;
          if (m_state == 1) begin
            m_frames++;
            for (int i = 0; i < N; i++) e_rdy[i] = (m_frames > i * GAP);
            if (e_rdy == 4'hF) m_state = 2;
          end
          if (m_init < N) begin
            d = m_init;
            m_init++;
          end else begin
            for (int i = 0; i < N; i++)
              if (m_pend[i] && d < 0) begin d = i; m_pend[i] = 1'b0; end
          end
          m_pend |= slot_new;
          if (d >= 0) model_draw(d);
        end
      end
      m_prev_start = start;
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
  endtask

  always @(posedge vsync) begin
    logic [85:0] act, exp;
    model_step();
    #1;
    act = {slot_rdy, slot_active, slot_back, slot_yvel, slot_xstart, total_fell, total_score, game_over};
    exp = {e_rdy, e_active, e_back, e_yvel, e_x, e_fell, e_score, (m_state == 3)};
    tests++;
    if (act !== exp) begin
      fails++;
      if (model_fail_prints < 20) begin
        model_fail_prints++;
        $display("FAIL model @%0t: got %0h expected %0h", $time, act, exp);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic [11:0] fell;
    logic [31:0] score;
    logic [2:0]  efell;
    logic [9:0]  escore;
  } vec_t;

  vec_t vecs[5];

  task automatic random_frames(input int n, input bit with_fell);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < N; i++) slot_new[i] = ($urandom_range(0, 7) == 0);
      slot_score = $urandom;
      if (with_fell) begin
        if ($urandom_range(0, 39) == 0)
          for (int i = 0; i < N; i++) slot_fell[3*i +: 3] = 3'($urandom_range(0, 1));
        if ($urandom_range(0, 299) == 0) start = ~start;
      end
      tick();
    end
    slot_new = '0;
  endtask

  initial begin
    logic [9:0] x;
    logic [4:0] yv;
    bit lfsr_ok;

    vecs[0] = '{12'h000, 32'h0,                      3'd0, 10'd0};
    vecs[1] = '{12'h001, {8'd4, 8'd3, 8'd2, 8'd1},   3'd1, 10'd10};
    vecs[2] = '{12'h048, {8'd200, 8'd0, 8'd0, 8'd100}, 3'd2, 10'd300};
    vecs[3] = '{12'h000, {4{8'hFF}},                 3'd0, 10'd1020};
    vecs[4] = '{12'h002, {8'd128, 8'd128, 8'd127, 8'd1}, 3'd2, 10'd384};

    // Reset state
    reset = 1'b1; start = 1'b1;
    repeat (3) tick();
    check("reset_rdy",    128'(slot_rdy), 128'(4'h0));
    check("reset_active", 128'(slot_active), 128'(4'hF));
    check("reset_params", 128'({slot_back, slot_yvel, slot_xstart}),
          128'({4'h0, {4{5'd18}}, {4{10'd200}}}));
    check("reset_totals", 128'({total_fell, total_score, game_over}), 128'(0));

    // Stagger timing: first edge after reset release is frame 0 (start rise)
    reset = 1'b0;
    for (int f = 0; f <= 95; f++) begin
      tick();
      if (f == 1)  check("stagger_f1",  128'(slot_rdy), 128'(4'b0001));
      if (f == 30) check("stagger_f30", 128'(slot_rdy), 128'(4'b0001));
      if (f == 31) check("stagger_f31", 128'(slot_rdy), 128'(4'b0011));
      if (f == 61) check("stagger_f61", 128'(slot_rdy), 128'(4'b0111));
      if (f == 91) check("stagger_f91", 128'(slot_rdy), 128'(4'b1111));
    end
    check("play_state", 128'(dut.state), 128'(2));

    // Relaunch of slots 0 and 2 in one frame
    slot_new = 4'b0101;
    tick();
    slot_new = '0;
    tick();
    x = slot_xstart[9:0]; yv = slot_yvel[4:0];
    check("x0_range",  128'(x >= 10'd200 && x <= 10'd711), 128'(1));
    check("back0",     128'(slot_back[0]), 128'(x > 10'd512));
    check("yv0_range", 128'(yv >= 5'd18 && yv <= 5'd25), 128'(1));
    tick();
    x = slot_xstart[29:20]; yv = slot_yvel[14:10];
    check("x2_range",  128'(x >= 10'd200 && x <= 10'd711), 128'(1));
    check("back2",     128'(slot_back[2]), 128'(x > 10'd512));
    check("yv2_range", 128'(yv >= 5'd18 && yv <= 5'd25), 128'(1));

    // Totals table
    for (int v = 0; v < 5; v++) begin
      slot_fell = vecs[v].fell; slot_score = vecs[v].score;
      tick();
      check($sformatf("vec%0d_fell", v),  128'(total_fell),  128'(vecs[v].efell));
      check($sformatf("vec%0d_score", v), 128'(total_score), 128'(vecs[v].escore));
      check($sformatf("vec%0d_over", v),  128'(game_over),   128'(0));
    end
    slot_fell = '0; slot_score = '0;

    random_frames(400, 1'b0);
    slot_score = '0;

    // Round end on third miss, totals frozen afterwards
    slot_fell = 12'h048;
    tick();
    check("fell2_total", 128'(total_fell), 128'(3'd2));
    check("fell2_noover", 128'(game_over), 128'(0));
    slot_fell = 12'h248;
    tick();
    check("over_flag", 128'({game_over, slot_rdy}), 128'({1'b1, 4'h0}));
    check("over_fell", 128'(total_fell), 128'(3'd3));
    slot_fell = '0;
    repeat (3) tick();
    check("over_frozen", 128'({game_over, total_fell}), 128'({1'b1, 3'd3}));

    // Restart from OVER
    start = 1'b0;
    tick();
    check("start_fall_ignored", 128'(game_over), 128'(1));
    start = 1'b1;
    tick();
    check("restart_clear", 128'({game_over, total_fell, total_score, slot_rdy}), 128'(0));
    tick();
    check("restart_slot0", 128'(slot_rdy), 128'(4'b0001));
    repeat (95) tick();

    random_frames(2000, 1'b1);

    // Reset in PLAY
    slot_fell = '0; slot_score = '0; start = 1'b1;
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (96) tick();
    check("replay_rdy", 128'({game_over, slot_rdy}), 128'({1'b0, 4'hF}));
    slot_score = {4{8'd50}};
    tick();
    reset = 1'b1;
    tick();
    check("midreset_rdy", 128'(slot_rdy), 128'(4'h0));
    check("midreset_params", 128'({slot_active, slot_back, slot_yvel, slot_xstart}),
          128'({4'hF, 4'h0, {4{5'd18}}, {4{10'd200}}}));
    check("midreset_totals", 128'({total_fell, total_score, game_over}), 128'(0));
    reset = 1'b0; start = 1'b0; slot_score = '0;
    lfsr_ok = 1'b1;
    for (int f = 0; f < 1024; f++) begin
      tick();
      if (dut.lfsr == 16'h0000) lfsr_ok = 1'b0;
    end
    check("lfsr_nonzero", 128'(lfsr_ok), 128'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
